// File: rtl/tdm_demux8_pkg.sv
// Shared constants and state encoding for the TDM demultiplexer.
// The slot width is tied to the fixed eight-channel frame.
package tdm_demux8_pkg;

  localparam int NCH    = 8;
  localparam int SLOT_W = 3;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux8_if.sv
// Sample-stream input and channel/frame outputs of the TDM demultiplexer.
// The master side feeds samples; the slave side is the demultiplexer.
interface tdm_demux8_if #(parameter int WIDTH = 8);
  import tdm_demux8_pkg::*;

  logic [WIDTH-1:0]     din;
  logic                 din_valid;
  logic                 frame_sync;
  logic [NCH*WIDTH-1:0] ch_data;
  logic [NCH-1:0]       ch_wr;
  logic [NCH*WIDTH-1:0] frame_data;
  logic                 frame_done;
  logic                 locked;
  logic                 sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  ch_data, ch_wr, frame_data, frame_done, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output ch_data, ch_wr, frame_data, frame_done, locked, sync_err
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot index counter for the receive framer: clear beats load-one beats increment.
// The three-bit slot wraps from 7 back to 0 on its own.
module tdm_slot_ctr
  import tdm_demux8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load1,
  input  logic              clr,
  output logic [SLOT_W-1:0] slot
);

  logic [SLOT_W-1:0] slot_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg <= '0;
    end else if (clr) begin
      slot_reg <= '0;
    end else if (load1) begin
      slot_reg <= SLOT_W'(1);
    end else if (inc) begin
      slot_reg <= slot_reg + SLOT_W'(1);
    end
  end

  assign slot = slot_reg;

endmodule

// File: rtl/tdm_demux8.sv
// Receive-side 8-channel TDM demultiplexer: steers samples into per-channel registers,
// tracks frame lock and publishes a snapshot of every complete in-order frame.
module tdm_demux8
  import tdm_demux8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  tdm_demux8_if.slave    bus
);

  state_t               state_reg, state_next;
  logic                 full_reg, full_next;
  logic [SLOT_W-1:0]    slot;
  logic                 inc, load1, clr;
  logic [NCH-1:0]       wr_ch;
  logic                 err, done;

  logic [WIDTH-1:0]     ch_reg [NCH];
  logic [NCH*WIDTH-1:0] frame_data_reg;
  logic [NCH-1:0]       ch_wr_reg;
  logic                 frame_done_reg;
  logic                 sync_err_reg;
  logic [NCH*WIDTH-1:0] ch_flat;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .load1 (load1),
    .clr   (clr),
    .slot  (slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_HUNT;
      full_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      full_reg  <= full_next;
    end
  end

  // full_reg marks that channel 0 of the current frame was captured, so slot 7 closes a whole frame.
  always_comb begin
    state_next = state_reg;
    full_next  = full_reg;
    wr_ch      = '0;
    inc        = 1'b0;
    load1      = 1'b0;
    clr        = 1'b0;
    err        = 1'b0;
    done       = 1'b0;
    if (bus.din_valid) begin
      case (state_reg)
        ST_HUNT: begin
          if (bus.frame_sync) begin
            wr_ch      = NCH'(1);
            load1      = 1'b1;
            full_next  = 1'b1;
            state_next = ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (bus.frame_sync) begin
            wr_ch     = NCH'(1);
            load1     = 1'b1;
            full_next = 1'b1;
            err       = (slot != '0);
          end else if (slot != '0) begin
            wr_ch = NCH'(1) << slot;
            inc   = 1'b1;
            done  = (slot == SLOT_W'(NCH - 1)) && full_reg;
          end else begin
            err        = 1'b1;
            clr        = 1'b1;
            full_next  = 1'b0;
            state_next = ST_HUNT;
          end
        end
        default: state_next = ST_HUNT;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ch_reg[gi] <= '0;
        end else if (wr_ch[gi]) begin
          ch_reg[gi] <= bus.din;
        end
      end
      assign ch_flat[gi*WIDTH +: WIDTH] = ch_reg[gi];
    end
  endgenerate

  // Snapshot uses the pre-edge channels 0..6 plus the slot-7 sample arriving now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_data_reg <= '0;
      ch_wr_reg      <= '0;
      frame_done_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      ch_wr_reg      <= wr_ch;
      frame_done_reg <= done;
      sync_err_reg   <= err;
      if (done) begin
        frame_data_reg <= {bus.din, ch_flat[(NCH-1)*WIDTH-1:0]};
      end
    end
  end

  assign bus.ch_data    = ch_flat;
  assign bus.ch_wr      = ch_wr_reg;
  assign bus.frame_data = frame_data_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.sync_err   = sync_err_reg;
  assign bus.locked     = (state_reg == ST_LOCK);

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8: a queue-based frame model predicts every
// output after each clock; scenario tasks drive directed and random streams.
module tb_tdm_demux8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tdm_demux8_if #(.WIDTH(8)) bus ();

  tdm_demux8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: samples collected since the last sync form the frame in progress.
  logic [7:0] exp_ch    [8];
  logic [7:0] exp_frame [8];
  logic [7:0] frame_q   [$];
  logic       locked_m;
  logic [7:0] exp_wr;
  logic       exp_done;
  logic       exp_err;

  function automatic logic [138:0] obs();
    return {bus.ch_wr, bus.frame_done, bus.sync_err, bus.locked, bus.ch_data, bus.frame_data};
  endfunction

  function automatic logic [138:0] expv();
    logic [63:0] c, f;
    for (int i = 0; i < 8; i++) begin
      c[i*8 +: 8] = exp_ch[i];
      f[i*8 +: 8] = exp_frame[i];
    end
    return {exp_wr, exp_done, exp_err, locked_m, c, f};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      exp_ch[i]    = 8'h00;
      exp_frame[i] = 8'h00;
    end
    frame_q.delete();
    locked_m = 1'b0;
    exp_wr   = 8'h00;
    exp_done = 1'b0;
    exp_err  = 1'b0;
  endfunction

  function automatic void model_step(input logic v, input logic s, input logic [7:0] d);
    int n;
    exp_wr   = 8'h00;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (!v) return;
    if (!locked_m) begin
      if (s) begin
        locked_m  = 1'b1;
        frame_q   = {d};
        exp_ch[0] = d;
        exp_wr    = 8'h01;
      end
      return;
    end
    if (s) begin
      if (frame_q.size() != 0) exp_err = 1'b1;
      frame_q   = {d};
      exp_ch[0] = d;
      exp_wr    = 8'h01;
    end else if (frame_q.size() == 0) begin
      exp_err  = 1'b1;
      locked_m = 1'b0;
    end else begin
      n         = frame_q.size();
      exp_ch[n] = d;
      exp_wr    = 8'h01 << n;
      frame_q.push_back(d);
      if (n == 7) begin
        exp_done = 1'b1;
        for (int i = 0; i < 8; i++) exp_frame[i] = frame_q[i];
        frame_q.delete();
      end
    end
  endfunction

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    bus.din_valid  = v;
    bus.frame_sync = s;
    bus.din        = d;
    model_step(v, s, d);
    @(posedge clk);
    #1;
    $display("t=%0t v=%b s=%b d=%02h ch_wr=%02h done=%b err=%b lk=%b",
             $time, v, s, d, bus.ch_wr, bus.frame_done, bus.sync_err, bus.locked);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.din_valid = 1'b0; bus.frame_sync = 1'b0; bus.din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (obs() !== expv()) $display("FAIL reset_init got %h want %h", obs(), expv());
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'hA5);
    drive(1'b1, 1'b0, 8'h3C);
    drive(1'b1, 1'b0, 8'h77);
    n_checks++;
    if (obs() !== expv()) $display("FAIL pre_reset got %h want %h", obs(), expv());
    else n_pass++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    n_checks++;
    if (obs() !== expv()) $display("FAIL async_reset got %h want %h", obs(), expv());
    else n_pass++;
    @(negedge clk);
    bus.din_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 8'($urandom));
      n_checks++;
      if (obs() !== expv() || bus.locked !== 1'b0)
        $display("FAIL hunt_no_sync step %0d got %h want %h", i, obs(), expv());
      else n_pass++;
    end
  endtask

  task automatic test_lock_frame();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0, 8'(8'h10 + i));
      n_checks++;
      if (obs() !== expv()) $display("FAIL lock_frame step %0d got %h want %h", i, obs(), expv());
      else n_pass++;
      n_checks++;
      if (bus.ch_wr !== 8'(1 << i) || bus.frame_done !== (i == 7))
        $display("FAIL ch_wr_walk step %0d got wr=%h done=%b want wr=%h", i, bus.ch_wr, bus.frame_done, 8'(1 << i));
      else n_pass++;
    end
    n_checks++;
    if (bus.frame_data !== 64'h1716151413121110 || bus.locked !== 1'b1)
      $display("FAIL lock_frame_data got %h lk=%b want 1716151413121110 lk=1", bus.frame_data, bus.locked);
    else n_pass++;
    drive(1'b0, 1'b0, 8'h00);
    n_checks++;
    if (obs() !== expv()) $display("FAIL done_pulse_end got %h want %h", obs(), expv());
    else n_pass++;
  endtask

  task automatic test_gaps();
    int errs = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0, 8'(8'h10 + i));
      n_checks++;
      if (obs() !== expv()) $display("FAIL gaps step %0d got %h want %h", i, obs(), expv());
      else n_pass++;
      errs += int'(bus.sync_err);
      if (i == 2 || i == 6) begin
        for (int g = 0; g < 2; g++) begin
          drive(1'b0, g[0], 8'($urandom));
          n_checks++;
          if (obs() !== expv()) $display("FAIL gap_idle step %0d got %h want %h", i, obs(), expv());
          else n_pass++;
          errs += int'(bus.sync_err);
        end
      end
    end
    n_checks++;
    if (bus.frame_data !== 64'h1716151413121110 || errs != 0)
      $display("FAIL gaps_frame got %h errs=%0d want 1716151413121110 errs=0", bus.frame_data, errs);
    else n_pass++;
  endtask

  task automatic test_early_sync();
    int errs = 0, dones = 0;
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, (i == 0) || (i == 5), 8'($urandom));
      n_checks++;
      if (obs() !== expv()) $display("FAIL early_sync step %0d got %h want %h", i, obs(), expv());
      else n_pass++;
      errs  += int'(bus.sync_err);
      dones += int'(bus.frame_done);
      if (i == 5) begin
        n_checks++;
        if (bus.sync_err !== 1'b1 || bus.ch_wr !== 8'h01 || bus.frame_done !== 1'b0)
          $display("FAIL early_sync_flag got err=%b wr=%h done=%b want err=1 wr=01 done=0",
                   bus.sync_err, bus.ch_wr, bus.frame_done);
        else n_pass++;
      end
    end
    n_checks++;
    if (errs != 1 || dones != 1) $display("FAIL early_sync_count got errs=%0d dones=%0d want 1 1", errs, dones);
    else n_pass++;
  endtask

  task automatic test_missing_sync();
    logic [7:0] ch0;
    ch0 = 8'($urandom);
    drive(1'b1, 1'b1, ch0);
    for (int i = 1; i < 8; i++) drive(1'b1, 1'b0, 8'($urandom));
    n_checks++;
    if (obs() !== expv()) $display("FAIL missing_sync_frame got %h want %h", obs(), expv());
    else n_pass++;
    drive(1'b1, 1'b0, ~ch0);
    n_checks++;
    if (bus.sync_err !== 1'b1 || bus.locked !== 1'b0 || bus.ch_data[7:0] !== ch0 || bus.ch_wr !== 8'h00)
      $display("FAIL missing_sync got err=%b lk=%b ch0=%h wr=%h want 1 0 %h 00",
               bus.sync_err, bus.locked, bus.ch_data[7:0], bus.ch_wr, ch0);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'($urandom));
      n_checks++;
      if (obs() !== expv()) $display("FAIL ignored_hunt step %0d got %h want %h", i, obs(), expv());
      else n_pass++;
    end
    drive(1'b1, 1'b1, 8'h5A);
    n_checks++;
    if (obs() !== expv()) $display("FAIL relock got %h want %h", obs(), expv());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] fr [3];
    int dones = 0;
    for (int f = 0; f < 3; f++) fr[f] = {$urandom, $urandom};
    // Complete the frame left open by the previous task before the three tracked frames.
    for (int i = 1; i < 8; i++) drive(1'b1, 1'b0, 8'($urandom));
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, i == 0, fr[f][i*8 +: 8]);
        n_checks++;
        if (obs() !== expv()) $display("FAIL b2b frame %0d slot %0d got %h want %h", f, i, obs(), expv());
        else n_pass++;
        dones += int'(bus.frame_done);
        if (i == 7) begin
          n_checks++;
          if (bus.frame_data !== fr[f]) $display("FAIL b2b_snapshot %0d got %h want %h", f, bus.frame_data, fr[f]);
          else n_pass++;
        end else if (f > 0) begin
          n_checks++;
          if (bus.frame_data !== fr[f-1]) $display("FAIL b2b_stable %0d got %h want %h", f, bus.frame_data, fr[f-1]);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (dones != 3) $display("FAIL b2b_count got %0d want 3", dones);
    else n_pass++;
  endtask

  task automatic test_random();
    logic v, s;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = (frame_q.size() == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      drive(v, s, 8'($urandom));
      n_checks++;
      if (obs() !== expv()) $display("FAIL random step %0d got %h want %h", i, obs(), expv());
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_frame();
    test_gaps();
    test_early_sync();
    test_missing_sync();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
